// File: rtl/armleocpu_ptw_rr.sv
// Sv32 page table walker shared by CHANNELS TLB clients through a round-robin arbiter.
// One walk is in flight at a time over a read-only Avalon-MM master.
module armleocpu_ptw_rr #(
    parameter int CHANNELS = 2,
    parameter int PA_WIDTH = 34
) (
    input  logic                     clk,
    input  logic                     rst,

    output logic [PA_WIDTH-1:0]      avl_address,
    output logic                     avl_read,
    input  logic [31:0]              avl_readdata,
    input  logic                     avl_readdatavalid,
    input  logic                     avl_waitrequest,
    input  logic [1:0]               avl_response,

    input  logic [CHANNELS-1:0]      req_valid,
    input  logic [20*CHANNELS-1:0]   req_vpn,
    output logic [CHANNELS-1:0]      req_ready,

    output logic                     resp_valid,
    output logic [CHANNELS-1:0]      resp_channel,
    output logic                     resp_pagefault,
    output logic                     resp_accessfault,
    output logic [7:0]               resp_access_bits,
    output logic [21:0]              resp_ppn,
    output logic                     resp_megapage,

    input  logic                     satp_mode,
    input  logic [21:0]              satp_ppn
);

    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state;
    state_t              state_next;

    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    ptr_next;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    cand;
    logic                grant_any;
    logic [CHANNELS-1:0] grant_onehot;
    logic [19:0]         grant_vpn;
    logic                accept;

    logic [19:0]         vpn;
    logic [21:0]         base;
    logic                level;
    logic [CHANNELS-1:0] chan;

    logic                res_pf;
    logic                res_af;
    logic [7:0]          res_bits;
    logic [21:0]         res_ppn;
    logic                res_mega;

    logic [33:0]         addr_full;
    logic                pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d;
    logic                pte_leaf;
    logic                pte_done;
    logic                walk_af, walk_pf, walk_ok, walk_descend;
    logic [21:0]         leaf_ppn;
    logic                unused_bits;

    // Round-robin scan: first valid channel at or after ptr, wrapping
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = PTR_W'((int'(ptr) + k) % CHANNELS);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        grant_vpn    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_any && (grant_idx == PTR_W'(i))) begin
                grant_onehot[i] = 1'b1;
                grant_vpn       = req_vpn[i*20 +: 20];
            end
        end
    end

    always_comb begin
        ptr_next = '0;
        if (int'(grant_idx) + 1 < CHANNELS) begin
            ptr_next = grant_idx + 1'b1;
        end
    end

    assign accept = (state == IDLE) && grant_any;

    assign addr_full = {base, (level ? vpn[19:10] : vpn[9:0]), 2'b00};

    assign pte_v    = avl_readdata[0];
    assign pte_r    = avl_readdata[1];
    assign pte_w    = avl_readdata[2];
    assign pte_x    = avl_readdata[3];
    assign pte_u    = avl_readdata[4];
    assign pte_a    = avl_readdata[6];
    assign pte_d    = avl_readdata[7];
    assign pte_leaf = pte_r | pte_x;
    assign pte_done = (state == WAIT) && avl_readdatavalid;

    // A level-1 leaf is a megapage: low PPN half comes from the VPN
    assign leaf_ppn = level ? {avl_readdata[31:20], vpn[9:0]} : avl_readdata[31:10];

    assign unused_bits = ^{avl_readdata[9:8], addr_full};

    // PTE classification, first match wins
    always_comb begin
        walk_af      = 1'b0;
        walk_pf      = 1'b0;
        walk_ok      = 1'b0;
        walk_descend = 1'b0;
        if (avl_response != 2'b00) begin
            walk_af = 1'b1;
        end else if (!pte_v || (!pte_r && pte_w)) begin
            walk_pf = 1'b1;
        end else if (pte_leaf && !pte_a) begin
            walk_pf = 1'b1;
        end else if (pte_leaf && level && (avl_readdata[19:10] != 10'd0)) begin
            walk_pf = 1'b1;
        end else if (pte_leaf) begin
            walk_ok = 1'b1;
        end else if (!level) begin
            walk_pf = 1'b1;
        end else if (pte_d || pte_a || pte_u) begin
            walk_pf = 1'b1;
        end else begin
            walk_descend = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = satp_mode ? ISSUE : RESP;
            ISSUE: if (!avl_waitrequest) state_next = WAIT;
            WAIT:  if (avl_readdatavalid) state_next = walk_descend ? ISSUE : RESP;
            RESP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            vpn      <= '0;
            base     <= '0;
            level    <= 1'b0;
            chan     <= '0;
            res_pf   <= 1'b0;
            res_af   <= 1'b0;
            res_bits <= '0;
            res_ppn  <= '0;
            res_mega <= 1'b0;
        end else if (accept) begin
            ptr      <= ptr_next;
            vpn      <= grant_vpn;
            base     <= satp_ppn;
            level    <= 1'b1;
            chan     <= grant_onehot;
            res_pf   <= 1'b0;
            res_af   <= 1'b0;
            res_mega <= 1'b0;
            // Bare mode: identity mapping with full permissions, answered without a walk
            res_ppn  <= satp_mode ? 22'd0 : {2'b00, grant_vpn};
            res_bits <= satp_mode ? 8'h00 : 8'hCF;
        end else if (pte_done) begin
            if (walk_descend) begin
                base  <= avl_readdata[31:10];
                level <= 1'b0;
            end else begin
                res_af   <= walk_af;
                res_pf   <= walk_pf;
                res_ppn  <= walk_ok ? leaf_ppn : 22'd0;
                res_bits <= walk_ok ? avl_readdata[7:0] : 8'h00;
                res_mega <= walk_ok && level;
            end
        end
    end

    always_comb begin
        avl_read         = 1'b0;
        avl_address      = '0;
        req_ready        = '0;
        resp_valid       = 1'b0;
        resp_channel     = '0;
        resp_pagefault   = 1'b0;
        resp_accessfault = 1'b0;
        resp_access_bits = '0;
        resp_ppn         = '0;
        resp_megapage    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: req_ready = grant_onehot;
                ISSUE: begin
                    avl_read    = 1'b1;
                    avl_address = addr_full[PA_WIDTH-1:0];
                end
                RESP: begin
                    resp_valid       = 1'b1;
                    resp_channel     = chan;
                    resp_pagefault   = res_pf;
                    resp_accessfault = res_af;
                    resp_access_bits = res_bits;
                    resp_ppn         = res_ppn;
                    resp_megapage    = res_mega;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_armleocpu_ptw_rr.sv
// Directed bench for armleocpu_ptw_rr: scripted Avalon slave plus response scoreboard.
module tb_armleocpu_ptw_rr;

    localparam int CH = 2;

    logic            clk;
    logic            rst;
    logic [33:0]     avl_address;
    logic            avl_read;
    logic [31:0]     avl_readdata;
    logic            avl_readdatavalid;
    logic            avl_waitrequest;
    logic [1:0]      avl_response;
    logic [CH-1:0]   req_valid;
    logic [20*CH-1:0] req_vpn;
    logic [CH-1:0]   req_ready;
    logic            resp_valid;
    logic [CH-1:0]   resp_channel;
    logic            resp_pagefault;
    logic            resp_accessfault;
    logic [7:0]      resp_access_bits;
    logic [21:0]     resp_ppn;
    logic            resp_megapage;
    logic            satp_mode;
    logic [21:0]     satp_ppn;

    armleocpu_ptw_rr #(.CHANNELS(CH), .PA_WIDTH(34)) dut (
        .clk(clk), .rst(rst),
        .avl_address(avl_address), .avl_read(avl_read),
        .avl_readdata(avl_readdata), .avl_readdatavalid(avl_readdatavalid),
        .avl_waitrequest(avl_waitrequest), .avl_response(avl_response),
        .req_valid(req_valid), .req_vpn(req_vpn), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_channel(resp_channel),
        .resp_pagefault(resp_pagefault), .resp_accessfault(resp_accessfault),
        .resp_access_bits(resp_access_bits), .resp_ppn(resp_ppn),
        .resp_megapage(resp_megapage),
        .satp_mode(satp_mode), .satp_ppn(satp_ppn)
    );

    typedef struct {
        logic [CH-1:0] ch;
        logic [21:0]   ppn;
        logic [7:0]    bits;
        logic          mega;
        logic          pf;
        logic          af;
        int            cyc;
    } resp_t;

    typedef struct {
        logic [33:0] addr;
        logic [31:0] data;
        logic [1:0]  rsp;
    } rd_t;

    resp_t exp_q[$];
    rd_t   rd_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int ws_left = 0;
    int rd_delay = 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic resp_t mk(input logic [CH-1:0] ch, input logic [21:0] ppn,
                                 input logic [7:0] bits, input logic mega,
                                 input logic pf, input logic af);
        resp_t r;
        r.ch = ch; r.ppn = ppn; r.bits = bits; r.mega = mega; r.pf = pf; r.af = af; r.cyc = 0;
        return r;
    endfunction

    task automatic push_rd(input logic [33:0] addr, input logic [31:0] data, input logic [1:0] rsp);
        rd_t r;
        r.addr = addr; r.data = data; r.rsp = rsp;
        rd_q.push_back(r);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Avalon slave: replays rd_q in order, inserts ws_left waitstates, returns data rd_delay cycles later
    initial begin
        rd_t cur;
        rd_t pend_item;
        bit  pend;
        bit  busy;
        int  pend_cnt;
        logic [33:0] hold;
        pend = 0; busy = 0; pend_cnt = 0; hold = '0;
        cur = '{default: '0};
        pend_item = '{default: '0};
        avl_waitrequest = 1'b0; avl_readdatavalid = 1'b0;
        avl_readdata = '0; avl_response = '0;
        forever begin
            @(posedge clk); #1;
            avl_readdatavalid = 1'b0;
            avl_readdata      = '0;
            avl_response      = '0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt <= 0) begin
                    avl_readdatavalid = 1'b1;
                    avl_readdata      = pend_item.data;
                    avl_response      = pend_item.rsp;
                    pend = 0;
                end
            end
            avl_waitrequest = 1'b0;
            if (avl_read) begin
                if (!busy) begin
                    busy = 1;
                    hold = avl_address;
                    chk("read_expected", 64'(rd_q.size() != 0), 64'd1);
                    if (rd_q.size() != 0) begin
                        cur = rd_q.pop_front();
                        chk("read_addr", 64'(avl_address), 64'(cur.addr));
                    end else begin
                        cur = '{default: '0};
                    end
                end else begin
                    chk("addr_stable", 64'(avl_address), 64'(hold));
                end
                if (ws_left > 0) begin
                    avl_waitrequest = 1'b1;
                    ws_left--;
                end else begin
                    busy = 0;
                    pend = 1;
                    pend_cnt = rd_delay;
                    pend_item = cur;
                end
            end
        end
    end

    // Scoreboard: every result strobe must match the oldest expected response
    initial begin
        resp_t e;
        forever begin
            @(posedge clk); #1;
            if (resp_valid) begin
                chk("resp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("resp_channel", 64'(resp_channel), 64'(e.ch));
                    chk("resp_ppn", 64'(resp_ppn), 64'(e.ppn));
                    chk("resp_bits", 64'(resp_access_bits), 64'(e.bits));
                    chk("resp_megapage", 64'(resp_megapage), 64'(e.mega));
                    chk("resp_pagefault", 64'(resp_pagefault), 64'(e.pf));
                    chk("resp_accessfault", 64'(resp_accessfault), 64'(e.af));
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Called at 2 time units after an edge; returns 3 units after the edge of the grant cycle
    task automatic wait_grant(output bit got);
        got = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (req_ready != '0) begin
                got = 1;
                break;
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic request(input int ch, input logic [19:0] v, input bit push,
                           input resp_t e, input int lat);
        bit got;
        resp_t x;
        x = e;
        req_vpn[ch*20 +: 20] = v;
        req_valid[ch] = 1'b1;
        wait_grant(got);
        chk("grant_seen", 64'(got), 64'd1);
        chk("grant_onehot", 64'(req_ready), 64'(1 << ch));
        if (got && push) begin
            x.cyc = cyc + lat;
            exp_q.push_back(x);
        end
        @(posedge clk); #2;
        req_valid[ch] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #2;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #2;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_avl_read"}, 64'(avl_read), 64'd0);
        chk({tag, "_avl_address"}, 64'(avl_address), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_resp_channel"}, 64'(resp_channel), 64'd0);
        chk({tag, "_resp_pf"}, 64'(resp_pagefault), 64'd0);
        chk({tag, "_resp_af"}, 64'(resp_accessfault), 64'd0);
        chk({tag, "_resp_bits"}, 64'(resp_access_bits), 64'd0);
        chk({tag, "_resp_ppn"}, 64'(resp_ppn), 64'd0);
        chk({tag, "_resp_mega"}, 64'(resp_megapage), 64'd0);
    endtask

    initial begin
        bit got;
        rst = 1'b1;
        req_valid = '0;
        req_vpn = '0;
        satp_mode = 1'b1;
        satp_ppn = 22'h00100;
        repeat (3) @(posedge clk);
        #2;
        req_valid = 2'b11;
        #1;
        check_zero("reset");
        req_valid = '0;
        rst = 1'b0;
        @(posedge clk); #2;

        // 4 KiB walk; satp change after acceptance must not disturb it
        push_rd(34'h0_0010_0004, 32'h0008_0001, 2'b00);
        push_rd(34'h0_0020_0004, 32'h048D_144F, 2'b00);
        request(0, 20'h00401, 1, mk(2'b01, 22'h12345, 8'h4F, 1'b0, 1'b0, 1'b0), 5);
        satp_ppn = 22'h3FFFF;
        drain();
        satp_ppn = 22'h00100;

        push_rd(34'h0_0010_0004, 32'h0010_0043, 2'b00);
        request(0, 20'h00401, 1, mk(2'b01, 22'h00401, 8'h43, 1'b1, 1'b0, 1'b0), 3);
        drain();

        push_rd(34'h0_0010_0004, 32'h0010_0443, 2'b00);
        request(0, 20'h00401, 1, mk(2'b01, 22'h0, 8'h0, 1'b0, 1'b1, 1'b0), 3);
        drain();

        push_rd(34'h0_0010_0004, 32'h0010_0043, 2'b10);
        request(0, 20'h00401, 1, mk(2'b01, 22'h0, 8'h0, 1'b0, 1'b0, 1'b1), 3);
        drain();

        push_rd(34'h0_0010_0004, 32'h0000_0004, 2'b00);
        request(0, 20'h00401, 1, mk(2'b01, 22'h0, 8'h0, 1'b0, 1'b1, 1'b0), 3);
        drain();

        push_rd(34'h0_0010_0004, 32'h0000_0005, 2'b00);
        request(0, 20'h00401, 1, mk(2'b01, 22'h0, 8'h0, 1'b0, 1'b1, 1'b0), 3);
        drain();

        push_rd(34'h0_0010_0004, 32'h0000_000F, 2'b00);
        request(0, 20'h00401, 1, mk(2'b01, 22'h0, 8'h0, 1'b0, 1'b1, 1'b0), 3);
        drain();

        push_rd(34'h0_0010_0004, 32'h0008_0041, 2'b00);
        request(0, 20'h00401, 1, mk(2'b01, 22'h0, 8'h0, 1'b0, 1'b1, 1'b0), 3);
        drain();

        push_rd(34'h0_0010_0004, 32'h0008_0001, 2'b00);
        push_rd(34'h0_0020_0004, 32'h0000_0001, 2'b00);
        request(0, 20'h00401, 1, mk(2'b01, 22'h0, 8'h0, 1'b0, 1'b1, 1'b0), 5);
        drain();

        ws_left = 3;
        push_rd(34'h0_0010_0004, 32'h0010_0043, 2'b00);
        request(0, 20'h00401, 1, mk(2'b01, 22'h00401, 8'h43, 1'b1, 1'b0, 1'b0), 6);
        drain();

        // Bare mode: no Avalon read is scripted, so any read is flagged
        satp_mode = 1'b0;
        request(0, 20'hABCDE, 1, mk(2'b01, 22'h0ABCDE, 8'hCF, 1'b0, 1'b0, 1'b0), 1);
        drain();
        request(1, 20'h12345, 1, mk(2'b10, 22'h012345, 8'hCF, 1'b0, 1'b0, 1'b0), 1);
        drain();

        // Both channels held valid: grants must alternate starting at ch0
        req_vpn = {20'h22222, 20'h11111};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant(got);
            chk("rr_grant_seen", 64'(got), 64'd1);
            chk("rr_grant", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            if (got) begin
                if (k % 2 == 0)
                    exp_q.push_back(mk(2'b01, 22'h011111, 8'hCF, 1'b0, 1'b0, 1'b0));
                else
                    exp_q.push_back(mk(2'b10, 22'h022222, 8'hCF, 1'b0, 1'b0, 1'b0));
                exp_q[exp_q.size() - 1].cyc = cyc + 1;
            end
            @(posedge clk); #2;
        end
        req_valid = '0;
        drain();
        satp_mode = 1'b1;

        // Reset during WAIT; the walk's data shows up late, after reset, in IDLE
        rd_delay = 3;
        push_rd(34'h0_0010_0004, 32'h0010_0043, 2'b00);
        request(0, 20'h00401, 0, mk(2'b01, 22'h0, 8'h0, 1'b0, 1'b0, 1'b0), 0);
        @(posedge clk); #2;
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        check_zero("rst_walk");
        @(posedge clk); #2;
        check_zero("rst_next");
        req_valid = '0;
        rst = 1'b0;
        rd_delay = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            chk("no_resp_after_rst", 64'(resp_valid), 64'd0);
        end

        push_rd(34'h0_0010_0004, 32'h0010_0043, 2'b00);
        req_vpn = {20'h00401, 20'h00401};
        req_valid = 2'b11;
        wait_grant(got);
        chk("rst_ptr_grant_seen", 64'(got), 64'd1);
        chk("rst_ptr_grant", 64'(req_ready), 64'd1);
        if (got) begin
            exp_q.push_back(mk(2'b01, 22'h00401, 8'h43, 1'b1, 1'b0, 1'b0));
            exp_q[exp_q.size() - 1].cyc = cyc + 3;
        end
        @(posedge clk); #2;
        req_valid = '0;
        drain();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("reads_consumed", 64'(rd_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/armleocpu_ptw_rr.md
# armleocpu_ptw_rr

Multi-requestor Sv32 page table walker. It accepts translation requests from `CHANNELS` TLB clients (ITLB and DTLB by default) through round-robin arbitration. For each accepted request it walks the two-level table over a read-only Avalon-MM master and returns a leaf PPN with access bits, a page fault, or an access fault. Compared with the single-client walker it adds:

- per-channel request/ready handshakes,
- a configurable physical address width,
- bare-mode passthrough,
- megapage PPN fill-in,
- A-bit and reserved-pointer-bit checking.

## Interface
Parameters:
- `CHANNELS`, 2, number of requestors (1..8).
- `PA_WIDTH`, 34, width of `avl_address` (32..34). Table address `{ppn,vpn_slice,2'b00}` is truncated to its low `PA_WIDTH` bits.

Ports:
- `clk`  in  1  clock. All logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `avl_address`  out  PA_WIDTH  PTE read address.
- `avl_read`  out  1  read request.
- `avl_readdata`  in  32  PTE data.
- `avl_readdatavalid`  in  1  read data valid.
- `avl_waitrequest`  in  1  slave stall.
- `avl_response`  in  2  response code; nonzero means error.
- `req_valid`  in  CHANNELS  per-channel request.
- `req_vpn`  in  20*CHANNELS  VPN; channel i occupies [20i+19:20i].
- `req_ready`  out  CHANNELS  one-hot grant.
- `resp_valid`  out  1  one-cycle result strobe.
- `resp_channel`  out  CHANNELS  one-hot owner of the result.
- `resp_pagefault`  out  1
- `resp_accessfault`  out  1
- `resp_access_bits`  out  8  leaf PTE[7:0].
- `resp_ppn`  out  22  translated PPN.
- `resp_megapage`  out  1  leaf was found at level 1.
- `satp_mode`  in  1  0 = bare, 1 = Sv32.
- `satp_ppn`  in  22  root table PPN.

## Operation
States: IDLE, ISSUE, WAIT, RESP.

**IDLE**
- The arbiter grants the first asserted `req_valid` at or after the priority pointer, scanning upward with wrap.
- `req_ready` is asserted combinationally for that channel only; it is zero when no request is pending.
- A request is accepted when `req_valid[i] & req_ready[i]`. The walker then captures `req_vpn[i]`, `satp_mode`, `satp_ppn` and the channel.
- The priority pointer moves to (i+1) mod CHANNELS.
- Next state: ISSUE with level=1 and base=`satp_ppn` when mode=1; RESP when mode=0.
- A requestor holds `req_valid` and `req_vpn` stable until it is granted.

**ISSUE**
- `avl_read`=1 and `avl_address`=`{base, vpn[level]}`, where vpn[1]=vpn[19:10] and vpn[0]=vpn[9:0], followed by `2'b00`.
- Address and read are held while `avl_waitrequest`=1.
- Go to WAIT on the first cycle with `avl_waitrequest`=0.

**WAIT**
- `avl_read`=0. The walker waits for `avl_readdatavalid`, then evaluates the PTE in the order below; the first match wins.
  1. `avl_response`≠0 → access fault.
  2. V=0, or (R=0 and W=1) → page fault.
  3. Leaf (R|X), but A=0 → page fault. No hardware A/D update is performed.
  4. Leaf at level 1 with PTE[19:10]≠0 (misaligned megapage) → page fault.
  5. Leaf, otherwise → success. `resp_ppn` = PTE[31:10] at level 0, or `{PTE[31:20], vpn[9:0]}` at level 1.
  6. Pointer (RWX=0) at level 0 → page fault.
  7. Pointer with any of D, A or U set → page fault.
  8. Pointer, otherwise → base=PTE[31:10], level=0, back to ISSUE.
- Every outcome except case 8 latches the result and goes to RESP.

**RESP**
- `resp_valid`=1 for exactly one cycle with the latched fields. `req_ready`=0. Next state: IDLE.
- Bare-mode result: `resp_ppn`={2'b00, vpn}, `resp_access_bits`=8'hCF, `resp_megapage`=0, no faults.
- At most one fault flag is ever set.
- On any fault, `resp_ppn` and `resp_access_bits` are 0 and `resp_megapage` is 0.

## Timing
Reset:
- While `rst`=1, every output is 0: `avl_read`, `avl_address`, `req_ready`, `resp_*`.
- State returns to IDLE, the priority pointer to 0, and all internal registers to 0.
- Reset mid-walk abandons the walk with no response. A `readdatavalid` still arriving from that walk is ignored in IDLE.

Latency (acceptance cycle T, no waitrequest, data returned one cycle after the read is accepted):
- Bare mode: `resp_valid` at T+1.
- Megapage or level-1 fault: read at T+1, data at T+2, `resp_valid` at T+3.
- 4 KiB page: reads at T+1 and T+3, `resp_valid` at T+5.
- Each waitrequest cycle adds one cycle; each readdatavalid delay cycle adds one cycle.

Throughput and ordering:
- Back-to-back acceptance is possible at the cycle after RESP.
- Exactly one walk is in flight at a time. Responses are in acceptance order.
- `satp` changes after acceptance do not affect the walk in progress.

## Test plan
- **4 KiB walk.** `satp_ppn`=22'h00100, ch0 vpn=20'h00401.
  - Expect read at 34'h0_0010_0004; return 32'h0008_0001.
  - Expect read at 34'h0_0020_0004; return 32'h048D_144F.
  - Expect `resp_ppn`=22'h12345, `resp_access_bits`=8'h4F, `resp_channel`=2'b01, `resp_valid` at T+5.
- **Megapage.** Same request; L1 PTE=32'h0010_0043.
  - Expect `resp_ppn`=22'h00401, `resp_megapage`=1, `resp_valid` at T+3.
  - L1 PTE=32'h0010_0443 instead → `resp_pagefault`=1.
- **Faults.**
  - `avl_response`=2'b10 on L1 → `resp_accessfault`=1.
  - PTE=32'h0000_0004 → page fault.
  - Leaf PTE=32'h0000_000F (A=0) → page fault.
  - Pointer at level 0 → page fault.
- **Round-robin.** CHANNELS=2, both valid continuously → grant order ch0, ch1, ch0, ch1. Each `resp_channel` matches its grant.
- **Waitrequest and bare mode.**
  - 3 cycles of `avl_waitrequest` → address stable throughout; latency +3.
  - `satp_mode`=0 with vpn=20'hABCDE → `resp_ppn`=22'h0ABCDE at T+1 with no Avalon read.
- **Reset mid-walk.** Assert `rst` during WAIT.
  - All outputs are 0 on the next cycle, and the late `readdatavalid` produces no `resp_valid`.
  - A fresh request then completes normally with the priority pointer back at 0.
